// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions raw player push-buttons for the game controller. Each channel is
// independent: the pin is normalised to 1 = pressed, passed through a 2-flop
// synchroniser, debounced by a stable-count filter, and turned into a clean
// level plus single-cycle press / release / move strobes.
//
// Optional feature macro: BUTTON_AUTOREPEAT_EN
//   defined     -> a per-channel repeat engine makes btn_move auto-repeat while
//                  a button is held (first repeat after REPEAT_DELAY cycles,
//                  then every REPEAT_PERIOD cycles).
//   not defined -> no repeat engine; btn_move is identical to btn_press.
//
// Parameters:
//   N_BUTTONS        number of independent channels
//   ACTIVE_LOW       1 = pin reads 0 when pressed
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   REPEAT_DELAY     cycles from accepted press to first repeat (>= 2)
//   REPEAT_PERIOD    cycles between later repeats (>= 2)
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_raw      raw asynchronous button pins
//   btn_level    debounced level, 1 = held
//   btn_press    one-cycle strobe on accepted 0->1
//   btn_release  one-cycle strobe on accepted 1->0
//   btn_move     one-cycle strobe: press OR repeat
// All outputs are registered; there is no combinational path from btn_raw.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BUTTONS       = 8,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_move
);

  localparam int              DC_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int              RC_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int              RC_W    = $clog2(RC_MAX);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
`endif

  // Internal polarity: 1 = pressed.
  logic [N_BUTTONS-1:0] norm;
  assign norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      logic            s1_q, s2_q;
      logic            lvl_q, lvl_d;
      logic [DC_W-1:0] dc_q, dc_d;
      logic            press_q, press_d;
      logic            release_q, release_d;
      logic            move_q, move_d;

      // Debouncer: dc counts consecutive cycles where the synchronised input
      // disagrees with the accepted level; any agreement restarts the count.
      always_comb begin
        lvl_d     = lvl_q;
        dc_d      = dc_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == lvl_q) begin
          dc_d = '0;
        end else if (dc_q == DC_LAST) begin
          lvl_d     = s2_q;
          dc_d      = '0;
          press_d   = s2_q;
          release_d = ~s2_q;
        end else begin
          dc_d = dc_q + DC_ONE;
        end
      end

`ifdef BUTTON_AUTOREPEAT_EN
      logic [RC_W-1:0] rc_q, rc_d;
      logic            first_q, first_d;
      logic            rep_d;

      // Repeat engine: rc measures time since the press (first interval) or
      // since the previous repeat (later intervals).
      always_comb begin
        rc_d    = rc_q;
        first_d = first_q;
        rep_d   = 1'b0;
        if (press_d) begin
          rc_d    = '0;
          first_d = 1'b1;
        end else if (lvl_q) begin
          if (rc_q == (first_q ? RD_LAST : RP_LAST)) begin
            // A release accepted on this edge swallows the repeat.
            rep_d   = ~release_d;
            rc_d    = '0;
            first_d = 1'b0;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
        end else begin
          rc_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rc_q    <= '0;
          first_q <= 1'b0;
        end else begin
          rc_q    <= rc_d;
          first_q <= first_d;
        end
      end

      assign move_d = press_d | rep_d;
`else
      assign move_d = press_d;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q      <= 1'b0;
          s2_q      <= 1'b0;
          lvl_q     <= 1'b0;
          dc_q      <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          move_q    <= 1'b0;
        end else begin
          s1_q      <= norm[gi];
          s2_q      <= s1_q;
          lvl_q     <= lvl_d;
          dc_q      <= dc_d;
          press_q   <= press_d;
          release_q <= release_d;
          move_q    <= move_d;
        end
      end

      assign btn_level[gi]   = lvl_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
      assign btn_move[gi]    = move_q;
    end
  endgenerate

endmodule
